// File: rtl/sipo_frame_pkg.sv
// Shared types and sizing helpers for the SIPO framing controller.
// The optional parity feature is selected by SIPO_PARITY_EN in the design files.
package sipo_frame_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_N = 8;

    // Bit counter must hold values up to N+1 (the parity-frame length).
    function automatic int cnt_width(input int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Enable-gated shift register; clear restarts it with the incoming bit.
// Width is chosen by the controller to hold only the bits it needs to keep.
module sipo_shift_core #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         shift_en,
    input  logic         clear,
    input  logic         si,
    output logic [W-1:0] sr
);

    generate
        if (W == 1) begin : g_one
            always_ff @(posedge clk) begin
                if (reset) begin
                    sr <= '0;
                end else if (shift_en || clear) begin
                    sr <= si;
                end
            end
        end else begin : g_wide
            always_ff @(posedge clk) begin
                if (reset) begin
                    sr <= '0;
                end else if (shift_en) begin
                    sr <= clear ? W'(si) : {sr[W-2:0], si};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Framing controller: counts strobed serial bits, loads completed words into a
// valid/ready holding register, flags overrun/frame errors. Optional: SIPO_PARITY_EN.
module sipo_frame_ctrl
    import sipo_frame_pkg::*;
#(
    parameter int  N     = DEFAULT_N,
    localparam int CNT_W = cnt_width(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         si_valid,
    input  logic         si,
    input  logic         sof,
    output logic [N-1:0] po,
    output logic         po_valid,
    input  logic         po_ready,
    output logic         busy,
    output logic         overrun,
    output logic         frame_err
`ifdef SIPO_PARITY_EN
    ,
    output logic         parity_err
`endif
);

    // Handshake: a word transfers on any edge where po_valid && po_ready;
    // po_valid only falls after such a transfer (or reset).

`ifdef SIPO_PARITY_EN
    localparam int F    = N + 1;
    localparam int SR_W = N;
`else
    // The last data bit is taken straight from si, so only N-1 bits are stored.
    localparam int F    = N;
    localparam int SR_W = N - 1;
`endif

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [SR_W-1:0]  sr;
    logic [N-1:0]     word;
    logic             last;
    logic             complete;
    logic             shift_en;

    always_comb begin
        last     = (state == SHIFT) && !sof && (count == CNT_W'(F - 1));
        complete = si_valid && last;
        // Bits past the N-th (the parity bit) are never shifted into the word.
        shift_en = si_valid && (sof || ((state == SHIFT) && (count < CNT_W'(N))));
    end

`ifdef SIPO_PARITY_EN
    assign word = sr;
`else
    assign word = {sr, si};
`endif

    sipo_shift_core #(
        .W(SR_W)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .clear    (si_valid && sof),
        .si       (si),
        .sr       (sr)
    );

    assign busy = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            po         <= '0;
            po_valid   <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;

            if (po_valid && po_ready) begin
                po_valid <= 1'b0;
            end

            if (complete) begin
                if (!po_valid || po_ready) begin
                    po         <= word;
                    po_valid   <= 1'b1;
`ifdef SIPO_PARITY_EN
                    parity_err <= (^word) ^ si;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (si_valid && sof) begin
                        state <= SHIFT;
                        count <= CNT_W'(1);
                    end
                end
                SHIFT: begin
                    if (si_valid) begin
                        if (sof) begin
                            frame_err <= 1'b1;
                            count     <= CNT_W'(1);
                        end else if (last) begin
                            state <= IDLE;
                            count <= '0;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl: expected words queued at stimulus time,
// popped by a monitor on each po handshake. Honours SIPO_PARITY_EN.
module tb_sipo_frame_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         si_valid;
    logic         si;
    logic         sof;
    logic [N-1:0] po;
    logic         po_valid;
    logic         po_ready;
    logic         busy;
    logic         overrun;
    logic         frame_err;
    logic         perr;

    int checks = 0;
    int errors = 0;
    int overrun_cnt = 0;
    int frame_err_cnt = 0;

    logic [N:0] exp_q[$];

    sipo_frame_ctrl #(
        .N(N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .si_valid   (si_valid),
        .si         (si),
        .sof        (sof),
        .po         (po),
        .po_valid   (po_valid),
        .po_ready   (po_ready),
        .busy       (busy),
        .overrun    (overrun),
        .frame_err  (frame_err)
`ifdef SIPO_PARITY_EN
        ,
        .parity_err (perr)
`endif
    );

`ifndef SIPO_PARITY_EN
    assign perr = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b, input logic s);
        si_valid = 1'b1;
        si       = b;
        sof      = s;
        @(posedge clk);
        #1;
        si_valid = 1'b0;
        sof      = 1'b0;
        si       = 1'b0;
    endtask

    // Sends one frame MSB first; ready_last raises po_ready just before the final bit.
    task automatic send_frame(input logic [N-1:0] w, input int gap, input bit push,
                              input bit ready_last, input bit par_flip);
        logic exp_perr;
`ifdef SIPO_PARITY_EN
        exp_perr = par_flip;
`else
        exp_perr = 1'b0;
`endif
        if (push) exp_q.push_back({exp_perr, w});
        for (int i = N - 1; i >= 0; i--) begin
            idle(gap);
`ifndef SIPO_PARITY_EN
            if (i == 0 && ready_last) po_ready = 1'b1;
`endif
            drive_bit(w[i], i == N - 1);
            if (i > 0) check("busy_mid_frame", 32'(busy), 32'd1);
        end
`ifdef SIPO_PARITY_EN
        idle(gap);
        if (ready_last) po_ready = 1'b1;
        drive_bit((^w) ^ par_flip, 1'b0);
`endif
    endtask

    initial begin
        reset    = 1'b1;
        si_valid = 1'b0;
        si       = 1'b0;
        sof      = 1'b0;
        po_ready = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (!reset) begin
                    if (overrun) overrun_cnt++;
                    if (frame_err) frame_err_cnt++;
                    if (po_valid && po_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL po_accept unexpected word actual=%0h", po);
                        end else begin
                            check("po_accept", 32'({perr, po}), 32'(exp_q.pop_front()));
                        end
                    end
                end
            end
        join_none

        idle(3);
        check("rst_po", 32'(po), 32'h0);
        check("rst_po_valid", 32'(po_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_parity_err", 32'(perr), 32'd0);
        reset = 1'b0;
        idle(1);

        // Back-to-back frame, consumer always ready.
        po_ready = 1'b1;
        send_frame(8'hB2, 0, 1'b1, 1'b0, 1'b0);
        check("b2_po", 32'(po), 32'hB2);
        check("b2_po_valid", 32'(po_valid), 32'd1);
        check("b2_busy_done", 32'(busy), 32'd0);
        idle(1);
        check("b2_po_valid_drop", 32'(po_valid), 32'd0);

        // Same frame with 3-cycle gaps between bits.
        send_frame(8'hB2, 3, 1'b1, 1'b0, 1'b0);
        check("gap_po", 32'(po), 32'hB2);
        check("gap_busy_done", 32'(busy), 32'd0);
        idle(2);

        // Holding register full: second word is dropped with an overrun pulse.
        po_ready = 1'b0;
        send_frame(8'hA5, 0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 0, 1'b0, 1'b0, 1'b0);
        check("ovr_pulse", 32'(overrun), 32'd1);
        check("ovr_po_kept", 32'(po), 32'hA5);
        idle(1);
        check("ovr_pulse_end", 32'(overrun), 32'd0);
        po_ready = 1'b1;
        idle(1);
        check("ovr_po_valid_drop", 32'(po_valid), 32'd0);
        check("ovr_po_retained", 32'(po), 32'hA5);

        // Completion and drain on the same edge.
        po_ready = 1'b0;
        send_frame(8'h11, 0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 0, 1'b1, 1'b1, 1'b0);
        check("swap_po", 32'(po), 32'h22);
        check("swap_po_valid", 32'(po_valid), 32'd1);
        check("swap_no_overrun", 32'(overrun), 32'd0);
        idle(1);
        check("swap_po_valid_drop", 32'(po_valid), 32'd0);

        // sof mid-frame after 5 bits restarts the frame.
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        send_frame(8'hF0, 0, 1'b1, 1'b0, 1'b0);
        check("ferr_po", 32'(po), 32'hF0);
        idle(2);
        check("ferr_count", 32'(frame_err_cnt), 32'd1);
        check("ovr_count", 32'(overrun_cnt), 32'd1);

`ifdef SIPO_PARITY_EN
        send_frame(8'h07, 0, 1'b1, 1'b0, 1'b0);
        check("par_ok", 32'(perr), 32'd0);
        idle(1);
        send_frame(8'h07, 0, 1'b1, 1'b0, 1'b1);
        check("par_bad", 32'(perr), 32'd1);
        idle(1);
`endif

        // Reset mid-frame with a held word: everything returns to reset values.
        po_ready = 1'b0;
        send_frame(8'h55, 0, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("mrst_po", 32'(po), 32'h0);
        check("mrst_po_valid", 32'(po_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_parity_err", 32'(perr), 32'd0);
        po_ready = 1'b1;
        send_frame(8'h5A, 0, 1'b1, 1'b0, 1'b0);
        check("mrst_next_po", 32'(po), 32'h5A);
        idle(3);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
